// File: rtl/dct_pkg.sv
// Shared constants and types for the JPEG DCT datapath.
package dct_pkg;

  localparam int unsigned DCT_N = 8;

  typedef enum logic [1:0] {TP_IDLE, TP_READ, TP_DRAIN} tp_state_t;

  function automatic int unsigned line_addr_width(input int unsigned max_w);
    return (max_w > 1) ? $clog2(max_w) : 1;
  endfunction

endpackage

// File: rtl/dct_tp_ram.sv
// Simple dual-port line memory: one write port, one registered 1-cycle read port.
module dct_tp_ram #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 1920,
  parameter int unsigned AW    = 11
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dct_transpose_ctrl.sv
// Row-to-column transpose between the two 1D-DCT passes: ping-pong stripe
// buffer written in raster order, read out as 8-high block columns.
module dct_transpose_ctrl
  import dct_pkg::*;
#(
  parameter int unsigned COEF_WIDTH     = 16,
  parameter int unsigned MAX_LINE_WIDTH = 1920
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [COEF_WIDTH-1:0]       coef_tdata,
  input  logic                        coef_tvalid,
  output logic                        coef_tready,
  input  logic                        coef_tuser,
  input  logic                        coef_tlast,
  output logic [DCT_N*COEF_WIDTH-1:0] col_tdata,
  output logic                        col_tvalid,
  input  logic                        col_tready,
  output logic                        col_tuser,
  output logic                        col_tlast,
  output logic [COEF_WIDTH-1:0]       col_tkeep,
  output logic [COEF_WIDTH-1:0]       col_tstrb,
  output logic                        err_o
);

  localparam int unsigned AW = line_addr_width(MAX_LINE_WIDTH);
  localparam int unsigned LW = AW + 2;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_LINE_WIDTH);

  logic [1:0]    full, full_set, full_clr, sof;
  logic          wr_bank, rd_bank;
  logic [2:0]    wr_row, eff_row, k;
  logic [LW-1:0] wr_col, eff_col, row_len, blk, nblk;
  logic [LW-1:0] line_len [2];
  logic          accept, restart, in_range, wr_close;

  tp_state_t     state;
  logic          pop, credit, issue, last_addr, rd_done;
  logic [1:0]    occ;
  logic [AW-1:0] rd_addr;
  logic          rd_v, rd_bank_q, rd_user_q, rd_last_q;
  logic [COEF_WIDTH-1:0]       rd_data [2][DCT_N];
  logic [DCT_N*COEF_WIDTH-1:0] ram_word, skid_data;
  logic          skid_v, skid_user, skid_last;

  assign col_tkeep = '1;
  assign col_tstrb = '1;

  // A tuser beat arriving mid-stripe is re-addressed to row 0 col 0.
  always_comb begin
    coef_tready = !full[wr_bank];
    accept      = coef_tvalid && coef_tready;
    restart     = coef_tuser && (wr_row != '0 || wr_col != '0);
    eff_row     = restart ? '0 : wr_row;
    eff_col     = restart ? '0 : wr_col;
    row_len     = eff_col + LW'(1);
    in_range    = eff_col < MAX_LEN;
    wr_close    = accept && coef_tlast && (eff_row == 3'd7);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_bank  <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      err_o    <= 1'b0;
      sof      <= '0;
      line_len <= '{default: '0};
    end else if (accept) begin
      if (restart || !in_range) err_o <= 1'b1;
      if (eff_row == '0 && eff_col == '0) sof[wr_bank] <= coef_tuser;
      if (coef_tlast) begin
        if (eff_row == '0) begin
          line_len[wr_bank] <= in_range ? row_len : MAX_LEN;
          if (row_len[2:0] != '0) err_o <= 1'b1;
        end else if (row_len != line_len[wr_bank]) begin
          err_o <= 1'b1;
        end
        wr_col <= '0;
        if (eff_row == 3'd7) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= eff_row + 3'd1;
        end
      end else begin
        wr_row <= eff_row;
        wr_col <= in_range ? row_len : eff_col;
      end
    end
  end

  // Read issue is credit-based: an address goes out only if its data is
  // guaranteed a slot in the two-entry output stage one cycle later.
  always_comb begin
    pop       = col_tvalid && col_tready;
    occ       = 2'(col_tvalid) + 2'(skid_v) + 2'(rd_v);
    credit    = (occ != 2'd2) || pop;
    issue     = ((state == TP_READ) || (state == TP_IDLE && full[rd_bank])) && credit;
    nblk      = line_len[rd_bank] >> 3;
    if (nblk == '0) nblk = LW'(1);
    last_addr = (k == 3'd7) && (blk == nblk - LW'(1));
    rd_addr   = AW'({blk, k});
    rd_done   = (state == TP_DRAIN) && pop && col_tlast;
    full_set  = '0;
    full_clr  = '0;
    if (wr_close) full_set[wr_bank] = 1'b1;
    if (rd_done)  full_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) full <= '0;
    else       full <= (full & ~full_clr) | full_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= TP_IDLE;
      rd_bank <= 1'b0;
      blk     <= '0;
      k       <= '0;
    end else begin
      case (state)
        TP_IDLE:  if (full[rd_bank]) state <= TP_READ;
        TP_READ:  if (issue && last_addr) state <= TP_DRAIN;
        TP_DRAIN: if (rd_done) begin
          state   <= TP_IDLE;
          rd_bank <= ~rd_bank;
        end
        default:  state <= TP_IDLE;
      endcase
      if (issue) begin
        if (k == 3'd7) begin
          k   <= '0;
          blk <= last_addr ? '0 : blk + LW'(1);
        end else begin
          k <= k + 3'd1;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar r = 0; r < DCT_N; r++) begin : g_row
      dct_tp_ram #(.DW(COEF_WIDTH), .DEPTH(MAX_LINE_WIDTH), .AW(AW)) u_ram (
        .clk_i (clk_i),
        .we    (accept && in_range && wr_bank == 1'(b) && eff_row == 3'(r)),
        .waddr (AW'(eff_col)),
        .wdata (coef_tdata),
        .re    (issue && rd_bank == 1'(b)),
        .raddr (rd_addr),
        .rdata (rd_data[b][r])
      );
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_v      <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_user_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_v      <= issue;
      rd_bank_q <= rd_bank;
      rd_user_q <= (blk == '0) && (k == '0) && sof[rd_bank];
      rd_last_q <= last_addr;
    end
  end

  always_comb begin
    ram_word = '0;
    for (int unsigned r = 0; r < DCT_N; r++)
      ram_word[r*COEF_WIDTH +: COEF_WIDTH] = rd_data[rd_bank_q][r];
  end

  // Output register is the FIFO head; skid holds the second entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_tvalid <= 1'b0;
      col_tdata  <= '0;
      col_tuser  <= 1'b0;
      col_tlast  <= 1'b0;
      skid_v     <= 1'b0;
      skid_data  <= '0;
      skid_user  <= 1'b0;
      skid_last  <= 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        col_tdata <= skid_data;
        col_tuser <= skid_user;
        col_tlast <= skid_last;
        if (rd_v) begin
          skid_data <= ram_word;
          skid_user <= rd_user_q;
          skid_last <= rd_last_q;
        end else begin
          skid_v <= 1'b0;
        end
      end else if (rd_v) begin
        col_tdata <= ram_word;
        col_tuser <= rd_user_q;
        col_tlast <= rd_last_q;
      end else begin
        col_tvalid <= 1'b0;
      end
    end else if (!col_tvalid) begin
      if (rd_v) begin
        col_tvalid <= 1'b1;
        col_tdata  <= ram_word;
        col_tuser  <= rd_user_q;
        col_tlast  <= rd_last_q;
      end
    end else if (rd_v) begin
      skid_v    <= 1'b1;
      skid_data <= ram_word;
      skid_user <= rd_user_q;
      skid_last <= rd_last_q;
    end
  end

endmodule
